// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and segment constants for the 7-segment scanner
package seg7_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } state_t;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} per hex nibble; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low segment decoder
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - four-digit multiplexed 7-segment scanner with dp flash on new values
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int FLASH_FRAMES = 8,
  parameter int LZ_BLANK     = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [15:0] DataIn,
  input  logic        DataValid,
  output logic [3:0]  nDigit,
  output logic [7:0]  nSegment,
  output logic        FrameEnd
);

  localparam int FC_W = (FLASH_FRAMES < 2) ? 1 : $clog2(FLASH_FRAMES + 1);

  logic [15:0]     cap_data;
  logic            cap_valid;
  logic            prev_valid;
  logic [15:0]     presc;
  logic [1:0]      idx;
  logic            started;
  logic            tick;
  logic            frame_end;
  logic            trigger;
  state_t          state, state_next;
  logic [FC_W-1:0] frame_cnt, frame_cnt_next;
  logic [15:0]     last_shown;
  logic [1:0]      nxt_idx;
  logic [3:0]      nibble;
  logic [6:0]      hex7;
  logic            lz_hit;
  logic [7:0]      seg_next;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cap_data   <= 16'h0000;
      cap_valid  <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      cap_data   <= DataIn;
      cap_valid  <= DataValid;
      prev_valid <= cap_valid;
    end
  end

  assign tick      = (presc == 16'(CLK_DIV - 1));
  assign frame_end = tick && (idx == 2'd3);
  assign FrameEnd  = frame_end;
  assign trigger   = cap_valid && (!prev_valid || (cap_data != last_shown));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      presc <= 16'h0000;
      idx   <= 2'd0;
    end else if (tick) begin
      presc <= 16'h0000;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // A trigger reload wins over a same-cycle frame decrement.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    case (state)
      ST_IDLE: begin
        if (trigger && (FLASH_FRAMES > 0)) begin
          state_next     = ST_FLASH;
          frame_cnt_next = FC_W'(FLASH_FRAMES);
        end
      end
      ST_FLASH: begin
        if (!cap_valid) begin
          state_next     = ST_IDLE;
          frame_cnt_next = '0;
        end else if (trigger) begin
          frame_cnt_next = FC_W'(FLASH_FRAMES);
        end else if (frame_end) begin
          if (frame_cnt <= FC_W'(1)) begin
            state_next     = ST_IDLE;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt - FC_W'(1);
          end
        end
      end
      default: begin
        state_next     = ST_IDLE;
        frame_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      last_shown <= 16'h0000;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      if (trigger) begin
        last_shown <= cap_data;
      end
    end
  end

  // Segments are computed for the slot about to start, using the post-tick state.
  assign nxt_idx = idx + 2'd1;
  assign nibble  = cap_data[{nxt_idx, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nibble   (nibble),
    .segments (hex7)
  );

  always_comb begin
    lz_hit = 1'b0;
    case (nxt_idx)
      2'd3:    lz_hit = (cap_data[15:12] == 4'h0);
      2'd2:    lz_hit = (cap_data[15:8] == 8'h00);
      2'd1:    lz_hit = (cap_data[15:4] == 12'h000);
      default: lz_hit = 1'b0;
    endcase
  end

  always_comb begin
    seg_next = {~(state_next == ST_FLASH), hex7};
    if (!cap_valid) begin
      seg_next = SEG_DASH;
    end else if ((LZ_BLANK != 0) && lz_hit) begin
      seg_next = SEG_BLANK;
    end
  end

  // Anodes stay off until the first slot after reset, and for one cycle at every slot start.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      nDigit   <= 4'hF;
      nSegment <= SEG_BLANK;
      started  <= 1'b0;
    end else if (tick) begin
      nDigit   <= 4'hF;
      nSegment <= seg_next;
      started  <= 1'b1;
    end else if (started) begin
      nDigit <= ~(4'b0001 << idx);
    end
  end

endmodule
